// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl_pkg
//  Description : Shared ARM pipeline package: SRAM controller state encoding,
//                default timing/base-address constants, pipeline opcodes and
//                the byte-to-SRAM-word address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_ctrl_pkg;

    // Controller states; each 16-bit half of a 32-bit word gets its own phase.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam int unsigned c_wait_cycles_def = 2;
    localparam logic [31:0] c_base_addr_def   = 32'd1024;

    // Execute-stage command codes used by the rest of the pipeline.
    localparam logic [3:0] c_op_mov = 4'b0001;
    localparam logic [3:0] c_op_mvn = 4'b1001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_adc = 4'b0011;
    localparam logic [3:0] c_op_sub = 4'b0100;
    localparam logic [3:0] c_op_sbc = 4'b0101;
    localparam logic [3:0] c_op_and = 4'b0110;
    localparam logic [3:0] c_op_orr = 4'b0111;
    localparam logic [3:0] c_op_eor = 4'b1000;
    localparam logic [3:0] c_op_ldr = 4'b0010;
    localparam logic [3:0] c_op_str = 4'b0010;

    // 32-bit word index relative to the SRAM window; arithmetic wraps mod 2^32
    // and the two misalignment bits fall away with the shift.
    function automatic logic [16:0] f_word_addr(input logic [31:0] addr,
                                                input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl_if
//  Description : Memory-stage request/response bus between the pipeline and
//                the SRAM controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface : sram_ctrl_if
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl
//  Description : 32-bit load/store to 16-bit asynchronous SRAM bridge. Each
//                access is split into a low and a high half-word phase, each
//                held WAIT_CYCLES cycles; ready stalls the pipeline meanwhile.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = c_wait_cycles_def,
    parameter logic [31:0] BASE_ADDR   = c_base_addr_def
) (
    input  wire              clk,
    input  wire              rst,        // asynchronous, active-low
    sram_ctrl_if.slave       bus,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_WE_N,
    output logic             SRAM_OE_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N
);

    localparam logic [3:0] c_last = 4'(WAIT_CYCLES - 1);

    sram_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        is_wr_q;
    logic [31:0] rdata_q;

    logic        req;
    logic        load;
    logic        active;
    logic        dq_drive;

    assign req = bus.rd_en | bus.wr_en;

    // Next-state, counter and latch-enable decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_q == c_last) begin
                    cnt_d   = 4'd0;
                    state_d = ST_HI;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_HI: begin
                if (cnt_q == c_last) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            // Always fall back to IDLE so a request still held by the same
            // instruction is seen as a new one only after the stall is lifted.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            word_q  <= 17'd0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                word_q  <= f_word_addr(bus.address, BASE_ADDR);
                wdata_q <= bus.write_data;
                is_wr_q <= bus.wr_en;   // simultaneous rd/wr resolves to write
            end
        end
    end

    // Read capture: each half is taken on the final cycle of its phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
        end else if (!is_wr_q && cnt_q == c_last) begin
            if (state_q == ST_LO) rdata_q[15:0]  <= SRAM_DQ;
            if (state_q == ST_HI) rdata_q[31:16] <= SRAM_DQ;
        end
    end

    assign active   = (state_q == ST_LO) || (state_q == ST_HI);
    assign dq_drive = active && is_wr_q;

    assign SRAM_DQ   = dq_drive ? ((state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0])
                                : 16'hzzzz;
    assign SRAM_ADDR = {word_q, (state_q == ST_HI)};
    assign SRAM_WE_N = ~(active &  is_wr_q);
    assign SRAM_OE_N = ~(active & ~is_wr_q);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign bus.read_data = rdata_q;
    assign bus.ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

endmodule : sram_ctrl
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_ctrl (with behavioural sram_model)
//  Description : Self-checking bench: three controller/SRAM pairs with
//                WAIT_CYCLES = 2, 1 and 4; a read scoreboard and shadow memory
//                provide expected data, latency and bus-sequence values.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_model #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  wire        clk,
    inout  wire [15:0] dq,
    input  wire [17:0] addr,
    input  wire        we_n,
    input  wire        oe_n,
    input  wire        ce_n,
    input  wire        ub_n,
    input  wire        lb_n
);
    logic [15:0] mem [0:262143];
    logic [17:0] prev_addr_q;
    logic        prev_act_q;
    int unsigned run_q;
    int unsigned age;
    logic        rd_act;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        prev_addr_q = '0;
        prev_act_q  = 1'b0;
        run_q       = 0;
    end

    assign rd_act = !ce_n && !oe_n && we_n;
    // Cycles the current read address has already been held before this one.
    assign age = (rd_act && prev_act_q && addr == prev_addr_q) ? run_q : 0;
    // Data is only valid once the address has been stable long enough.
    assign dq = rd_act ? ((age >= WAIT_CYCLES - 1) ? mem[addr] : 16'hEEEE) : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n && !ub_n && !lb_n) mem[addr] <= dq;
        run_q       <= rd_act ? ((prev_act_q && addr == prev_addr_q) ? run_q + 1 : 1) : 0;
        prev_act_q  <= rd_act;
        prev_addr_q <= addr;
    end
endmodule : sram_model

module tb_sram_ctrl;
    logic clk;
    logic rst_n;

    logic        wr_en_a  [3];
    logic        rd_en_a  [3];
    logic [31:0] addr_a   [3];
    logic [31:0] wdata_a  [3];
    logic [31:0] rdata_a  [3];
    logic        ready_a  [3];
    logic [17:0] saddr_a  [3];
    logic        we_n_a   [3];
    logic        oe_n_a   [3];

    int          n_checks;
    int          n_fail;
    logic [31:0] sb_q [$];
    logic [31:0] shadow [int];
    logic [31:0] last_rd [3];

    function automatic int w_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 4 : 2);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_inst
        sram_ctrl_if bus ();
        wire [15:0] dq;
        wire [17:0] sa;
        wire        we_n, oe_n, ce_n, ub_n, lb_n;

        assign bus.wr_en      = wr_en_a[k];
        assign bus.rd_en      = rd_en_a[k];
        assign bus.address    = addr_a[k];
        assign bus.write_data = wdata_a[k];
        assign rdata_a[k]     = bus.read_data;
        assign ready_a[k]     = bus.ready;
        assign saddr_a[k]     = sa;
        assign we_n_a[k]      = we_n;
        assign oe_n_a[k]      = oe_n;

        sram_ctrl #(.WAIT_CYCLES(w_of(k)), .BASE_ADDR(32'd1024)) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .bus       (bus.slave),
            .SRAM_DQ   (dq),
            .SRAM_ADDR (sa),
            .SRAM_WE_N (we_n),
            .SRAM_OE_N (oe_n),
            .SRAM_CE_N (ce_n),
            .SRAM_UB_N (ub_n),
            .SRAM_LB_N (lb_n)
        );

        sram_model #(.WAIT_CYCLES(w_of(k))) u_mem (
            .clk  (clk),
            .dq   (dq),
            .addr (sa),
            .we_n (we_n),
            .oe_n (oe_n),
            .ce_n (ce_n),
            .ub_n (ub_n),
            .lb_n (lb_n)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        return 17'((a - 32'd1024) >> 2);
    endfunction

    // One access on instance k; inputs stay asserted on return (DONE cycle).
    task automatic access(input int k, input bit wr, input bit rd,
                          input logic [31:0] a, input logic [31:0] d);
        int          w;
        int          lat;
        bit          seen;
        logic [16:0] wd;
        logic [31:0] exp;
        w    = w_of(k);
        wd   = word_of(a);
        seen = 1'b0;
        lat  = 999;
        @(posedge clk); #1;
        wr_en_a[k] = wr; rd_en_a[k] = rd; addr_a[k] = a; wdata_a[k] = d;
        if (!wr) sb_q.push_back(shadow.exists(k * 1048576 + int'(wd)) ?
                                shadow[k * 1048576 + int'(wd)] : 32'd0);
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_eq("addr_lo", {14'd0, saddr_a[k]}, {14'd0, wd, 1'b0});
                check_eq("strobe_lo", {31'd0, wr ? we_n_a[k] : oe_n_a[k]}, 32'd0);
            end
            if (cyc == w + 1)
                check_eq("addr_hi", {14'd0, saddr_a[k]}, {14'd0, wd, 1'b1});
            if (ready_a[k]) begin
                seen = 1'b1;
                lat  = cyc;
                break;
            end
        end
        check_eq("latency", 32'(lat), 32'(2 * w + 1));
        if (wr) begin
            check_eq("rd_unchanged", rdata_a[k], last_rd[k]);
            shadow[k * 1048576 + int'(wd)] = d;
        end else begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0BAD0;
            if (seen) begin
                check_eq("read_data", rdata_a[k], exp);
                last_rd[k] = exp;
            end
        end
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        wr_en_a[k] = 1'b0; rd_en_a[k] = 1'b0;
    endtask

    task automatic check_model(input int k, input int idx, input logic [15:0] exp);
        logic [15:0] v;
        case (k)
            0:       v = g_inst[0].u_mem.mem[idx];
            1:       v = g_inst[1].u_mem.mem[idx];
            default: v = g_inst[2].u_mem.mem[idx];
        endcase
        check_eq("model_word", {16'd0, v}, {16'd0, exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_en_a[k] = 1'b0; rd_en_a[k] = 1'b0;
            addr_a[k]  = 32'd0; wdata_a[k] = 32'd0; last_rd[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_ready", {31'd0, ready_a[k]}, 32'd1);
            check_eq("rst_rdata", rdata_a[k], 32'd0);
            check_eq("rst_we_n", {31'd0, we_n_a[k]}, 32'd1);
            check_eq("rst_oe_n", {31'd0, oe_n_a[k]}, 32'd1);
        end
        rst_n = 1'b1;

        // Default timing: write, held read repeated, second word, dual request.
        access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        idle(0);
        check_model(0, 0, 16'hBEEF);
        check_model(0, 1, 16'hDEAD);
        access(0, 1'b0, 1'b1, 32'd1024, 32'h0);
        access(0, 1'b0, 1'b1, 32'd1024, 32'h0);
        idle(0);
        access(0, 1'b1, 1'b0, 32'd1028, 32'h12345678);
        access(0, 1'b0, 1'b1, 32'd1024, 32'h0);
        access(0, 1'b0, 1'b1, 32'd1029, 32'h0);
        idle(0);
        access(0, 1'b1, 1'b1, 32'd1036, 32'hA5A5A5A5);
        idle(0);
        access(0, 1'b0, 1'b1, 32'd1036, 32'h0);
        idle(0);

        // Short and long wait-state variants.
        for (int k = 1; k < 3; k++) begin
            access(k, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
            idle(k);
            check_model(k, 0, 16'hBEEF);
            check_model(k, 1, 16'hDEAD);
            access(k, 1'b1, 1'b0, 32'd1028, 32'h12345678);
            access(k, 1'b0, 1'b1, 32'd1024, 32'h0);
            access(k, 1'b0, 1'b1, 32'd1028, 32'h0);
            idle(k);
        end

        // Reset asserted during the high phase of a write.
        @(posedge clk); #1;
        wr_en_a[0] = 1'b1; addr_a[0] = 32'd1032; wdata_a[0] = 32'hCAFEF00D;
        repeat (w_of(0) + 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        wr_en_a[0] = 1'b0;
        #1;
        check_eq("midrst_we_n", {31'd0, we_n_a[0]}, 32'd1);
        check_eq("midrst_oe_n", {31'd0, oe_n_a[0]}, 32'd1);
        check_eq("midrst_ready", {31'd0, ready_a[0]}, 32'd1);
        check_eq("midrst_rdata", rdata_a[0], 32'd0);
        check_eq("midrst_rdata2", rdata_a[2], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
        access(0, 1'b0, 1'b1, 32'd1028, 32'h0);
        idle(0);
        access(2, 1'b0, 1'b1, 32'd1024, 32'h0);
        idle(2);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule : tb_sram_ctrl
`default_nettype wire
